// File: rtl/operand_triple_packer.sv
// rtl/operand_triple_packer.sv - packs a serial operand stream into (a,b,c) triples for the 3-operand adder stage
// A three-state packer collects words into a DEPTH-entry triple FIFO; sum_valid tracks pops through the adder latency.
module operand_triple_packer #(
    parameter int W     = 6,
    parameter int DEPTH = 4,
    parameter int LAT   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [W-1:0]               in_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       flush,
    output logic [W-1:0]               a_s,
    output logic [W-1:0]               b_s,
    output logic [W-1:0]               c_s,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       sum_valid,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    typedef enum logic [1:0] {
        S_A = 2'd0,
        S_B = 2'd1,
        S_C = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [W-1:0]   stage_a, stage_b;
    logic [3*W-1:0] mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic [LW-1:0]  level_q;
    logic [LAT-1:0] sv_pipe;

    logic full, accept, push, pop;

    assign full      = (level_q == LW'(DEPTH));
    assign out_valid = (level_q != '0);
    // The full check uses the registered level only, so out_ready never reaches in_ready.
    assign in_ready  = !flush && !((state_q == S_C) && full);
    assign accept    = in_valid && in_ready;
    assign push      = accept && (state_q == S_C);
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_A;
        end else if (accept) begin
            case (state_q)
                S_A:     state_d = S_B;
                S_B:     state_d = S_C;
                S_C:     state_d = S_A;
                default: state_d = S_A;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            stage_a <= '0;
            stage_b <= '0;
        end else if (accept) begin
            if (state_q == S_A) stage_a <= in_data;
            if (state_q == S_B) stage_b <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {stage_a, stage_b, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      level_q <= level_q + LW'(1);
            else if (pop && !push) level_q <= level_q - LW'(1);
        end
    end

    // Shifting left keeps this valid for any LAT >= 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sv_pipe <= '0;
        end else begin
            sv_pipe <= (sv_pipe << 1) | LAT'(pop);
        end
    end

    assign sum_valid = sv_pipe[LAT-1];
    assign level     = level_q;
    assign a_s       = out_valid ? mem[rd_ptr][3*W-1:2*W] : '0;
    assign b_s       = out_valid ? mem[rd_ptr][2*W-1:W]   : '0;
    assign c_s       = out_valid ? mem[rd_ptr][W-1:0]     : '0;

endmodule

// File: tb/tb_operand_triple_packer.sv
// tb/tb_operand_triple_packer.sv - self-checking bench for operand_triple_packer
// A queue-based reference model tracks collected words, queued triples and pop history.
module tb_operand_triple_packer;

    localparam int W     = 6;
    localparam int DEPTH = 4;
    localparam int LAT   = 2;
    localparam int LW    = $clog2(DEPTH+1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          flush = 1'b0;
    logic [W-1:0]  a_s, b_s, c_s;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          sum_valid;
    logic [LW-1:0] level;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0]   part_m [$];
    logic [3*W-1:0] fifo_m [$];
    bit             hist [int];
    int             cyc = 0;

    operand_triple_packer #(.W(W), .DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .flush(flush), .a_s(a_s), .b_s(b_s), .c_s(c_s), .out_valid(out_valid),
        .out_ready(out_ready), .sum_valid(sum_valid), .level(level)
    );

    always #5 clk = ~clk;

    function automatic bit exp_in_ready();
        return !flush && !(part_m.size() == 2 && fifo_m.size() == DEPTH);
    endfunction

    function automatic logic [3*W-1:0] exp_head();
        return (fifo_m.size() > 0) ? fifo_m[0] : '0;
    endfunction

    function automatic bit exp_sum_valid();
        return hist.exists(cyc - LAT) ? hist[cyc - LAT] : 1'b0;
    endfunction

    // Advance the model with the inputs present at this edge, then step the clock.
    task automatic tick();
        bit rdy, pp;
        rdy = exp_in_ready();
        pp  = (fifo_m.size() > 0) && out_ready;
        hist[cyc] = pp;
        if (rst) begin
            part_m.delete();
            fifo_m.delete();
            hist.delete();
        end else begin
            if (pp) void'(fifo_m.pop_front());
            if (flush) begin
                part_m.delete();
            end else if (in_valid && rdy) begin
                part_m.push_back(in_data);
                if (part_m.size() == 3) begin
                    fifo_m.push_back({part_m[0], part_m[1], part_m[2]});
                    part_m.delete();
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] d);
        in_valid = 1'b1;
        in_data  = d;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        n_cmp++; if ({a_s, b_s, c_s} !== '0) begin n_bad++; $display("FAIL reset_abc got=%0h exp=0", {a_s, b_s, c_s}); end
        n_cmp++; if (level !== '0) begin n_bad++; $display("FAIL reset_level got=%0d exp=0", level); end
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL reset_sum_valid got=%0b exp=0", sum_valid); end
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        send(6'd5);
        send(6'd9);
        send(6'd63);
        n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_out_valid got=%0b exp=1", out_valid); end
        n_cmp++; if ({a_s, b_s, c_s} !== {6'd5, 6'd9, 6'd63}) begin n_bad++; $display("FAIL single_abc got=%0d,%0d,%0d exp=5,9,63", a_s, b_s, c_s); end
        n_cmp++; if (6'(a_s + b_s + c_s) !== 6'd13) begin n_bad++; $display("FAIL single_sum got=%0d exp=13", 6'(a_s + b_s + c_s)); end
        tick();
        out_ready = 1'b0;
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL single_sv_early got=%0b exp=0", sum_valid); end
        tick();
        n_cmp++; if (sum_valid !== 1'b1) begin n_bad++; $display("FAIL single_sv_lat got=%0b exp=1", sum_valid); end
        tick();
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL single_sv_once got=%0b exp=0", sum_valid); end
    endtask

    task automatic test_fill();
        logic [3*W-1:0] got [$];
        bit accepted15 = 1'b0;
        out_ready = 1'b0;
        for (int w = 1; w <= 14; w++) begin
            in_valid = 1'b1;
            in_data  = W'(w);
            #1;
            if (w >= 13) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_accept_w%0d got=%0b exp=1", w, in_ready); end
            end
            tick();
            if (w == 12) begin
                n_cmp++; if (level !== LW'(4)) begin n_bad++; $display("FAIL fill_level got=%0d exp=4", level); end
            end
        end
        in_data = 6'd15;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fill_stall_w15 got=%0b exp=0", in_ready); end
        out_ready = 1'b1;
        for (int k = 0; k < 20 && got.size() < 5; k++) begin
            if (k == 1) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fill_w15_after_pop got=%0b exp=1", in_ready); end
            end
            if (out_valid) got.push_back({a_s, b_s, c_s});
            if (in_valid && in_ready) accepted15 = 1'b1;
            tick();
            if (accepted15) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (got.size() != 5) begin n_bad++; $display("FAIL fill_count got=%0d exp=5", got.size()); end
        for (int t = 0; t < 5 && t < got.size(); t++) begin
            logic [3*W-1:0] e;
            e = {W'(3*t+1), W'(3*t+2), W'(3*t+3)};
            n_cmp++; if (got[t] !== e) begin n_bad++; $display("FAIL fill_order_%0d got=%0h exp=%0h", t, got[t], e); end
        end
        tick();
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(6'd7);
        send(6'd8);
        in_valid = 1'b1;
        in_data  = 6'(99);
        flush    = 1'b1;
        #1;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL flush_reject got=%0b exp=0", in_ready); end
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        send(6'd1);
        send(6'd2);
        send(6'd3);
        n_cmp++; if ({a_s, b_s, c_s} !== {6'd1, 6'd2, 6'd3}) begin n_bad++; $display("FAIL flush_head got=%0d,%0d,%0d exp=1,2,3", a_s, b_s, c_s); end
        n_cmp++; if (level !== LW'(1)) begin n_bad++; $display("FAIL flush_level got=%0d exp=1", level); end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 14; i++) send(W'($urandom_range(0, 63)));
        in_valid = 1'b1;
        in_data  = 6'd33;
        out_ready = 1'b1;
        #1;
        n_cmp++; if (level !== LW'(4)) begin n_bad++; $display("FAIL fullpop_level4 got=%0d exp=4", level); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fullpop_stall got=%0b exp=0", in_ready); end
        tick();
        out_ready = 1'b0;
        #1;
        n_cmp++; if (level !== LW'(3)) begin n_bad++; $display("FAIL fullpop_level3 got=%0d exp=3", level); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fullpop_ready got=%0b exp=1", in_ready); end
        tick();
        in_valid = 1'b0;
        n_cmp++; if (level !== LW'(4)) begin n_bad++; $display("FAIL fullpop_pushed got=%0d exp=4", level); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 9; i++) send(W'(i + 20));
        out_ready = 1'b1;
        send(6'd40);
        out_ready = 1'b0;
        n_cmp++; if (level !== LW'(2)) begin n_bad++; $display("FAIL rstmid_pre_level got=%0d exp=2", level); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (level !== '0) begin n_bad++; $display("FAIL rstmid_level got=%0d exp=0", level); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_out_valid got=%0b exp=0", out_valid); end
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_sum_valid got=%0b exp=0", sum_valid); end
        send(6'd11);
        n_cmp++; if (sum_valid !== 1'b0) begin n_bad++; $display("FAIL rstmid_sv_killed got=%0b exp=0", sum_valid); end
        send(6'd12);
        send(6'd13);
        n_cmp++; if ({a_s, b_s, c_s} !== {6'd11, 6'd12, 6'd13}) begin n_bad++; $display("FAIL rstmid_fresh got=%0d,%0d,%0d exp=11,12,13", a_s, b_s, c_s); end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = W'($urandom_range(0, 63));
            out_ready = (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            #1;
            n_cmp++; if (in_ready !== exp_in_ready()) begin n_bad++; $display("FAIL rand_in_ready cyc=%0d got=%0b exp=%0b", cyc, in_ready, exp_in_ready()); end
            n_cmp++; if (out_valid !== (fifo_m.size() > 0)) begin n_bad++; $display("FAIL rand_out_valid cyc=%0d got=%0b exp=%0b", cyc, out_valid, fifo_m.size() > 0); end
            n_cmp++; if (level !== LW'(fifo_m.size())) begin n_bad++; $display("FAIL rand_level cyc=%0d got=%0d exp=%0d", cyc, level, fifo_m.size()); end
            n_cmp++; if ({a_s, b_s, c_s} !== exp_head()) begin n_bad++; $display("FAIL rand_head cyc=%0d got=%0h exp=%0h", cyc, {a_s, b_s, c_s}, exp_head()); end
            n_cmp++; if (sum_valid !== exp_sum_valid()) begin n_bad++; $display("FAIL rand_sum_valid cyc=%0d got=%0b exp=%0b", cyc, sum_valid, exp_sum_valid()); end
            tick();
        end
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_single();
        test_fill();
        test_flush();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
